// File: rtl/transposed_block_pkg.sv
// Shared widths and limits for the transposed FIR tap and its optional saturating adder.
package transposed_block_pkg;

    localparam int DEFAULT_N = 16;

    function automatic int acc_width(input int n);
        return 2 * n;
    endfunction

    localparam int ACC_W = acc_width(DEFAULT_N);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

endpackage

// File: rtl/tap_sat_add.sv
// Signed W-bit adder clamping to the most positive/negative value on overflow.
// Purely combinational, no handshake.
module tap_sat_add
    import transposed_block_pkg::*;
#(
    parameter int W = ACC_W
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] sum_o
);

    localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    logic signed [W-1:0] raw_sum;
    logic                pos_ovf;
    logic                neg_ovf;

    assign raw_sum = a_i + b_i;

    // Overflow only when both operands share a sign and the result flips it.
    assign pos_ovf = !a_i[W-1] && !b_i[W-1] &&  raw_sum[W-1];
    assign neg_ovf =  a_i[W-1] &&  b_i[W-1] && !raw_sum[W-1];

    always_comb begin
        sum_o = raw_sum;
        if (pos_ovf) begin
            sum_o = SAT_MAX;
        end else if (neg_ovf) begin
            sum_o = SAT_MIN;
        end
    end

endmodule

// File: rtl/transposed_block.sv
// One transposed-FIR tap: summed_signal = normal_signal*coeff + delay_q; to_register lands one cycle later.
// Product path is combinational, no handshake; TAP_SATURATE_EN makes the final add saturate instead of wrap.
module transposed_block
    import transposed_block_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic signed [N-1:0]         normal_signal,
    input  logic signed [N-1:0]         coeff,
    input  logic signed [2*N-1:0]       to_register,
    output logic signed [2*N-1:0]       summed_signal
);

    localparam int W = acc_width(N);

    logic signed [W-1:0] delay_d;
    logic signed [W-1:0] delay_q;
    logic signed [W-1:0] product;

    assign delay_d = to_register;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            delay_q <= '0;
        end else begin
            delay_q <= delay_d;
        end
    end

    // Sign-extend both operands so the full 2N-bit product is exact, including (-2^(N-1))^2.
    assign product = $signed({{N{normal_signal[N-1]}}, normal_signal})
                   * $signed({{N{coeff[N-1]}}, coeff});

`ifdef TAP_SATURATE_EN
    tap_sat_add #(
        .W(W)
    ) u_sat_add (
        .a_i   (product),
        .b_i   (delay_q),
        .sum_o (summed_signal)
    );
`else
    assign summed_signal = product + delay_q;
`endif

endmodule

// File: tb/tb_transposed_block.sv
// Bench for transposed_block: reset, latency, signed products, overflow, async reset and a 3-tap chain.
module tb_transposed_block;
    import transposed_block_pkg::*;

    localparam int N = 16;
    localparam int W = 32;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic signed [N-1:0] normal_signal = '0;
    logic signed [N-1:0] coeff = '0;
    logic signed [W-1:0] to_register = '0;
    logic signed [W-1:0] summed_signal;

    // Separate 3-tap chain: first product uses coefficient 1, then taps with 2 and 3.
    logic signed [N-1:0] chain_x = '0;
    logic signed [W-1:0] chain_p0;
    logic signed [W-1:0] chain_a;
    logic signed [W-1:0] chain_y;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [N-1:0] ns;
        logic [N-1:0] cf;
        logic [W-1:0] tr;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    transposed_block #(.N(N)) dut (
        .clk           (clk),
        .reset         (reset),
        .normal_signal (normal_signal),
        .coeff         (coeff),
        .to_register   (to_register),
        .summed_signal (summed_signal)
    );

    assign chain_p0 = {{N{chain_x[N-1]}}, chain_x};

    transposed_block #(.N(N)) u_chain_a (
        .clk           (clk),
        .reset         (reset),
        .normal_signal (chain_x),
        .coeff         (16'sd2),
        .to_register   (chain_p0),
        .summed_signal (chain_a)
    );

    transposed_block #(.N(N)) u_chain_b (
        .clk           (clk),
        .reset         (reset),
        .normal_signal (chain_x),
        .coeff         (16'sd3),
        .to_register   (chain_a),
        .summed_signal (chain_y)
    );

    task automatic check(input string name, input logic [W-1:0] actual);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got 0x%08h", name, actual);
        end else begin
            e = exp_q.pop_front();
            n_checks++;
            if (actual !== e) begin
                n_fail++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, e);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h0000, 16'h0000, 32'h0000_0000, 32'd100};
        vecs[1] = '{16'hFFFE, 16'h0007, 32'h0000_0000, 32'hFFFF_FFF2};
        vecs[2] = '{16'h8000, 16'h8000, 32'h7FFF_FFFF, 32'h4000_0000};
`ifdef TAP_SATURATE_EN
        vecs[3] = '{16'h0001, 16'h0001, 32'h8000_0000, ACC_MAX};
        vecs[4] = '{16'hFFFF, 16'h0001, 32'h0000_0005, ACC_MIN};
`else
        vecs[3] = '{16'h0001, 16'h0001, 32'h8000_0000, 32'h8000_0000};
        vecs[4] = '{16'hFFFF, 16'h0001, 32'h0000_0005, 32'h7FFF_FFFF};
`endif
        vecs[5] = '{16'h7FFF, 16'h7FFF, 32'hFFFF_FFFD, 32'h3FFF_0006};
        vecs[6] = '{16'h8000, 16'h7FFF, 32'h0000_0000, 32'hC000_7FFD};
        vecs[7] = '{16'h000C, 16'hFFF4, 32'h0000_0000, 32'hFFFF_FF70};

        // Reset held: product only, stable across edges.
        #1;
        reset = 1'b0;
        normal_signal = 16'sd3;
        coeff = 16'sd5;
        to_register = 32'sd100;
        #1;
        exp_q.push_back(32'd15);
        check("reset_hold", summed_signal);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            exp_q.push_back(32'd15);
            check($sformatf("reset_edge%0d", i), summed_signal);
        end

        // Latency: one edge brings to_register in; product change is immediate.
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(32'd115);
        check("latency_first_edge", summed_signal);
        normal_signal = 16'sd0;
        #1;
        exp_q.push_back(32'd100);
        check("latency_comb_product", summed_signal);

        for (int i = 0; i < 8; i++) begin
            normal_signal = vecs[i].ns;
            coeff = vecs[i].cf;
            to_register = vecs[i].tr;
            exp_q.push_back(vecs[i].exp);
            #1;
            check($sformatf("vec%0d", i), summed_signal);
            @(posedge clk);
            #1;
        end

        // Async reset mid-stream drops the stored partial sum without a clock.
        normal_signal = 16'sd0;
        coeff = 16'sd0;
        to_register = 32'sd1000;
        @(posedge clk);
        #1;
        normal_signal = 16'sd2;
        coeff = 16'sd3;
        #1;
        exp_q.push_back(32'd1006);
        check("midreset_before", summed_signal);
        #1;
        reset = 1'b0;
        #1;
        exp_q.push_back(32'd6);
        check("midreset_async", summed_signal);
        to_register = 32'sd77;
        @(negedge clk);
        reset = 1'b1;
        #1;
        exp_q.push_back(32'd6);
        check("midreset_released", summed_signal);
        @(posedge clk);
        #1;
        exp_q.push_back(32'd83);
        check("midreset_reload", summed_signal);

        // Impulse through the 3-tap chain.
        chain_x = 16'sd1;
        exp_q.push_back(32'd3);
        exp_q.push_back(32'd2);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd0);
        #1;
        check("chain_t0", chain_y);
        for (int i = 1; i < 4; i++) begin
            @(posedge clk);
            #1;
            chain_x = 16'sd0;
            #1;
            check($sformatf("chain_t%0d", i), chain_y);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
